// File: rtl/ext_mode_sequencer.sv
// Result FIFO: first-word fall-through store for array results.
// Latency: a pushed entry is visible at the head one cycle later; a pop frees the slot the same cycle.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
module ext_mode_res_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic [DW-1:0]            head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count    = wptr - rptr;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty and wraps naturally.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

// External-mode sequencer: loads weights, streams input vectors, drains the array, collects results.
// Latency: every ext_* output and done_o is registered, one cycle after the accepting handshake.
// Backpressure: x_ready drops unless the result FIFO can hold everything in flight plus a full drain.
module ext_mode_sequencer #(
    parameter int WIDTH     = 8,
    parameter int ROW       = 4,
    parameter int COL       = 4,
    parameter int RES_DEPTH = 8,
    parameter int MAX_VEC   = 255
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic [$clog2(MAX_VEC+1)-1:0]  n_vec_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    input  logic [COL*WIDTH-1:0]          w_data_i,
    input  logic                          x_valid_i,
    output logic                          x_ready_o,
    input  logic [ROW*WIDTH-1:0]          x_data_i,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    output logic [COL*WIDTH-1:0]          r_data_o,
    output logic                          ext_en_o,
    output logic [COL*WIDTH-1:0]          ext_weight_o,
    output logic                          ext_weight_en_o,
    output logic [ROW*WIDTH-1:0]          ext_input_o,
    output logic                          ext_valid_o,
    input  logic [COL*WIDTH-1:0]          ext_result_i,
    input  logic                          ext_result_valid_i,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int NW  = $clog2(MAX_VEC+1);
    localparam int WCW = $clog2(ROW+1);
    localparam int DCW = $clog2(ROW);
    localparam int CW  = $clog2(RES_DEPTH) + 1;
    localparam int OW  = CW + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FINISH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NW-1:0]   n_vec_r;
    logic [NW-1:0]   x_cnt;
    logic [WCW-1:0]  w_cnt;
    logic [DCW-1:0]  d_cnt;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   res_cnt;
    logic [OW-1:0]   occ;
    logic            res_empty;
    logic            res_full;
    logic            res_push;
    logic            res_pop;
    logic            w_acc;
    logic            x_acc;
    logic            job_start;
    logic            ovf_r;

    logic                 ext_en_nxt;
    logic [COL*WIDTH-1:0] ext_weight_nxt;
    logic                 ext_weight_en_nxt;
    logic [ROW*WIDTH-1:0] ext_input_nxt;
    logic                 ext_valid_nxt;
    logic                 done_nxt;

    assign job_start = (state == IDLE) && start_i;
    assign busy_o    = (state != IDLE);
    assign w_ready_o = (state == LOAD_W);
    assign w_acc     = w_valid_i && w_ready_o;
    // Occupancy counts results already stored plus results owed for accepted vectors.
    assign occ       = OW'(res_cnt) + OW'(in_flight);
    assign x_ready_o = (state == STREAM) && (occ <= OW'(RES_DEPTH - ROW - 1));
    assign x_acc     = x_valid_i && x_ready_o;
    assign res_push  = (state != IDLE) && ext_result_valid_i;
    assign res_pop   = r_ready_i && r_valid_o;
    assign r_valid_o = !res_empty;

    ext_mode_res_fifo #(
        .DW    (COL*WIDTH),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push     (res_push),
        .push_dat (ext_result_i),
        .pop      (r_ready_i),
        .head_dat (r_data_o),
        .empty    (res_empty),
        .full     (res_full),
        .count    (res_cnt)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: phase lengths come from the beat counters.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start_i) state_nxt = LOAD_W;
            LOAD_W: if (w_acc && (w_cnt == WCW'(ROW-1)))
                        state_nxt = (n_vec_r == '0) ? FINISH : STREAM;
            STREAM: if (x_acc && (x_cnt == n_vec_r - NW'(1))) state_nxt = DRAIN;
            DRAIN:  if (d_cnt == DCW'(ROW-2)) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered array-side bundle.
    always_comb begin
        ext_en_nxt        = 1'b0;
        ext_weight_nxt    = ext_weight_o;
        ext_weight_en_nxt = 1'b0;
        ext_input_nxt     = ext_input_o;
        ext_valid_nxt     = 1'b0;
        done_nxt          = 1'b0;
        unique case (state)
            IDLE:   ext_en_nxt = start_i;
            LOAD_W: begin
                ext_en_nxt = 1'b1;
                if (w_acc) begin
                    ext_weight_nxt    = w_data_i;
                    ext_weight_en_nxt = 1'b1;
                end
            end
            STREAM: begin
                ext_en_nxt    = 1'b1;
                ext_valid_nxt = x_acc;
                ext_input_nxt = x_acc ? x_data_i : '0;
            end
            DRAIN: begin
                ext_en_nxt    = 1'b1;
                ext_valid_nxt = 1'b1;
                ext_input_nxt = '0;
            end
            FINISH: done_nxt = 1'b1;
            default: ext_en_nxt = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ext_en_o        <= 1'b0;
            ext_weight_o    <= '0;
            ext_weight_en_o <= 1'b0;
            ext_input_o     <= '0;
            ext_valid_o     <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            ext_en_o        <= ext_en_nxt;
            ext_weight_o    <= ext_weight_nxt;
            ext_weight_en_o <= ext_weight_en_nxt;
            ext_input_o     <= ext_input_nxt;
            ext_valid_o     <= ext_valid_nxt;
            done_o          <= done_nxt;
        end
    end

    // Job length latch and beat counters, all cleared when a job starts.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            n_vec_r <= '0;
            w_cnt   <= '0;
            x_cnt   <= '0;
            d_cnt   <= '0;
        end else if (job_start) begin
            n_vec_r <= n_vec_i;
            w_cnt   <= '0;
            x_cnt   <= '0;
            d_cnt   <= '0;
        end else begin
            if (w_acc)           w_cnt <= w_cnt + WCW'(1);
            if (x_acc)           x_cnt <= x_cnt + NW'(1);
            if (state == DRAIN)  d_cnt <= d_cnt + DCW'(1);
        end
    end

    // Results owed by the array: one per accepted vector, retired by each captured result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_flight <= '0;
        end else if (job_start) begin
            in_flight <= '0;
        end else begin
            unique case ({x_acc, res_push && (in_flight != '0)})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Sticky overflow: a result arrived with no room and no pop to make room.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                               ovf_r <= 1'b0;
        else if (res_push && res_full && !res_pop) ovf_r <= 1'b1;
    end
endmodule

// File: tb/tb_ext_mode_sequencer.sv
// Bench for ext_mode_sequencer: drives host streams, models the array, scoreboards results.
// Latency: the array model returns a result three cycles after each nonzero ext_valid_o cycle.
// Backpressure: the host result-ready is held low in some phases to exercise the reservation.
module tb_ext_mode_sequencer;
    localparam int WIDTH = 8, ROW = 4, COL = 4, RES_DEPTH = 8, MAX_VEC = 255;
    localparam int NW = $clog2(MAX_VEC+1);
    localparam logic [31:0] MASK = 32'hA5A5_5A5A;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [NW-1:0]        n_vec = '0;
    logic                 w_valid = 1'b0, w_ready;
    logic [COL*WIDTH-1:0] w_data = '0;
    logic                 x_valid = 1'b0, x_ready;
    logic [ROW*WIDTH-1:0] x_data = '0;
    logic                 r_valid, r_ready;
    logic [COL*WIDTH-1:0] r_data;
    logic                 ext_en, ext_weight_en, ext_valid, busy, done;
    logic [COL*WIDTH-1:0] ext_weight, ext_result;
    logic [ROW*WIDTH-1:0] ext_input;
    logic                 ext_result_valid;

    ext_mode_sequencer #(
        .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .RES_DEPTH(RES_DEPTH), .MAX_VEC(MAX_VEC)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .n_vec_i(n_vec),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .x_valid_i(x_valid), .x_ready_o(x_ready), .x_data_i(x_data),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .ext_en_o(ext_en), .ext_weight_o(ext_weight), .ext_weight_en_o(ext_weight_en),
        .ext_input_o(ext_input), .ext_valid_o(ext_valid),
        .ext_result_i(ext_result), .ext_result_valid_i(ext_result_valid),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Array model: a fixed 3-cycle pipe from each nonzero input beat to a result.
    logic [2:0]  v_sr = '0;
    logic [31:0] d_sr [3];
    logic        force_vld = 1'b0;
    logic [31:0] force_dat = '0;
    always @(posedge clk) begin
        if (!rstn) v_sr <= '0;
        else       v_sr <= {v_sr[1:0], ext_valid && (ext_input != '0)};
        d_sr[0] <= ext_input ^ MASK;
        d_sr[1] <= d_sr[0];
        d_sr[2] <= d_sr[1];
    end
    assign ext_result_valid = v_sr[2] | force_vld;
    assign ext_result       = force_vld ? force_dat : d_sr[2];

    // Scoreboards.
    logic [31:0] exp_q[$];
    logic [31:0] wexp_q[$];
    logic        host_rdy = 1'b0;
    assign r_ready = host_rdy;

    int pop_cnt = 0, wen_cnt = 0, wen_run = 0, wen_max = 0;
    int vin_cnt = 0, vzero_cnt = 0, done_cnt = 0, x_acc_cnt = 0;

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (r_valid && r_ready) begin
                check_eq("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("pop_data", r_data, exp_q.pop_front());
                pop_cnt++;
            end
            if (ext_weight_en) begin
                wen_cnt++;
                wen_run++;
                if (wen_run > wen_max) wen_max = wen_run;
                check_eq("w_expected", wexp_q.size() != 0, 1);
                if (wexp_q.size() != 0) check_eq("w_bus", ext_weight, wexp_q.pop_front());
            end else begin
                wen_run = 0;
            end
            if (ext_valid) begin
                if (ext_input != '0) vin_cnt++;
                else                 vzero_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        n_vec = NW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d);
        w_valid = 1'b1;
        w_data  = d;
        for (int t = 0; t < 50 && !w_ready; t++) tick();
        check_eq("w_ready_wait", w_ready, 1);
        wexp_q.push_back(d);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [31:0] d);
        x_valid = 1'b1;
        x_data  = d;
        for (int t = 0; t < 200 && !x_ready; t++) tick();
        check_eq("x_ready_wait", x_ready, 1);
        exp_q.push_back(d ^ MASK);
        x_acc_cnt++;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 100 && !done; t++) tick();
        check_eq("done_seen", done, 1);
    endtask

    task automatic drain_all();
        host_rdy = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
        tick();
        check_eq("drain_left", exp_q.size(), 0);
        check_eq("drain_rvalid", r_valid, 0);
    endtask

    int base_v, base_z, base_d, base_w, base_p, base_x;

    initial begin
        // Reset state.
        repeat (3) tick();
        check_eq("rst_ctrl", {r_valid, w_ready, x_ready, ext_en, ext_weight_en, ext_valid, busy, done}, 8'h00);
        check_eq("rst_bus", {ext_weight, ext_input, r_data}, 96'h0);
        rstn = 1'b1;
        tick();
        check_eq("idle_busy", busy, 0);

        // Weight-only job.
        base_v = vin_cnt + vzero_cnt; base_d = done_cnt; base_w = wen_cnt; wen_max = 0;
        start_job(0);
        check_eq("ld_en", {ext_en, busy}, 2'b11);
        for (int i = 1; i <= ROW; i++) send_w(32'(i));
        wait_done();
        repeat (3) tick();
        check_eq("wo_wen_cnt", wen_cnt - base_w, ROW);
        check_eq("wo_wen_run", wen_max, ROW);
        check_eq("wo_no_valid", vin_cnt + vzero_cnt - base_v, 0);
        check_eq("wo_done_cnt", done_cnt - base_d, 1);
        check_eq("wo_ext_en", ext_en, 0);

        // Three-vector job with a free-running host.
        host_rdy = 1'b1;
        base_v = vin_cnt; base_z = vzero_cnt; base_d = done_cnt; base_p = pop_cnt;
        start_job(3);
        for (int i = 0; i < ROW; i++) send_w(32'h1000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) send_x(32'h1122_3344 + 32'(i) * 32'h0101_0101);
        wait_done();
        check_eq("j3_vin", vin_cnt - base_v, 3);
        check_eq("j3_drain", vzero_cnt - base_z, ROW - 1);
        drain_all();
        check_eq("j3_pops", pop_cnt - base_p, 3);
        check_eq("j3_done_cnt", done_cnt - base_d, 1);

        // Result backpressure: six vectors, host not reading at first.
        host_rdy = 1'b0;
        base_x = x_acc_cnt; base_p = pop_cnt;
        start_job(6);
        for (int i = 0; i < ROW; i++) send_w(32'h2000_0000 + 32'(i));
        fork
            begin
                for (int i = 0; i < 6; i++) send_x(32'h2100_0001 + 32'(i));
            end
            begin
                repeat (40) tick();
                check_eq("bp_accepts", x_acc_cnt - base_x, RES_DEPTH - ROW);
                check_eq("bp_xready", x_ready, 0);
                check_eq("bp_occ", dut.res_cnt, RES_DEPTH - ROW);
                host_rdy = 1'b1;
            end
        join
        wait_done();
        drain_all();
        check_eq("bp_pops", pop_cnt - base_p, 6);
        check_eq("bp_ovf", dut.ovf_r, 0);

        // Reset in the middle of streaming.
        host_rdy = 1'b0;
        start_job(5);
        for (int i = 0; i < ROW; i++) send_w(32'h3000_0000 + 32'(i));
        for (int i = 0; i < 2; i++) send_x(32'h3100_0001 + 32'(i));
        rstn = 1'b0;
        #2;
        check_eq("mrst_ctrl", {r_valid, w_ready, x_ready, ext_en, ext_weight_en, ext_valid, busy, done}, 8'h00);
        check_eq("mrst_bus", {ext_weight, ext_input, r_data}, 96'h0);
        exp_q.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        check_eq("mrst_idle", {busy, r_valid}, 2'b00);
        host_rdy = 1'b1;
        base_v = vin_cnt; base_p = pop_cnt;
        start_job(5);
        for (int i = 0; i < ROW; i++) send_w(32'h3200_0000 + 32'(i));
        for (int i = 0; i < 5; i++) send_x(32'h3300_0001 + 32'(i));
        wait_done();
        drain_all();
        check_eq("mrst_vin", vin_cnt - base_v, 5);
        check_eq("mrst_pops", pop_cnt - base_p, 5);

        // Full FIFO: fill, push and pop together across the wrap, then overflow.
        host_rdy = 1'b0;
        start_job(0);
        for (int i = 0; i < RES_DEPTH; i++) begin
            force_vld = 1'b1;
            force_dat = 32'hC0DE_0000 + 32'(i);
            exp_q.push_back(force_dat);
            tick();
        end
        force_vld = 1'b0;
        check_eq("ff_occ", dut.res_cnt, RES_DEPTH);
        for (int i = 0; i < 5; i++) begin
            host_rdy  = 1'b1;
            force_vld = 1'b1;
            force_dat = 32'hC0DE_1000 + 32'(i);
            exp_q.push_back(force_dat);
            tick();
        end
        host_rdy  = 1'b0;
        force_vld = 1'b0;
        check_eq("ff_pp_occ", dut.res_cnt, RES_DEPTH);
        check_eq("ff_pp_ovf", dut.ovf_r, 0);
        force_vld = 1'b1;
        force_dat = 32'hDEAD_BEEF;
        tick();
        force_vld = 1'b0;
        check_eq("ff_ovf", dut.ovf_r, 1);
        check_eq("ff_ovf_occ", dut.res_cnt, RES_DEPTH);
        for (int i = 0; i < ROW; i++) send_w(32'h4000_0000 + 32'(i));
        wait_done();
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ext_mode_sequencer.md
Name: ext_mode_sequencer

Overview:
- Host-side initiator for the matrix multiplier's external (memory-bypass) mode.
- Accepts weight rows and input vectors from a host over valid/ready streams, then drives the external-input bundle (weight, weight-enable, input, valid) and holds ext_en high.
- Captures every result the array flags valid into a result FIFO, which the host drains over valid/ready.
- Sits between the host/test harness and the matrix multiplier's external ports.

Parameters:
- WIDTH, 8, element width in bits
- ROW, 4, systolic array rows; also the number of weight rows loaded and the drain length
- COL, 4, systolic array columns
- RES_DEPTH, 8, result FIFO depth in entries (power of 2, at least ROW+1)
- MAX_VEC, 255, maximum vectors per job; sets the n_vec_i width as $clog2(MAX_VEC+1)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  job start pulse; sampled only in IDLE
- n_vec_i  in  $clog2(MAX_VEC+1)  input vectors in the job; sampled with start_i; 0 = weight load only
- w_valid_i / w_ready_o  in/out  1  weight stream handshake
- w_data_i  in  COL*WIDTH  weight row
- x_valid_i / x_ready_o  in/out  1  input stream handshake
- x_data_i  in  ROW*WIDTH  input vector
- r_valid_o / r_ready_i  out/in  1  result stream handshake
- r_data_o  out  COL*WIDTH  result row (FIFO head)
- ext_en_o  out  1  external mode enable to the array
- ext_weight_o  out  COL*WIDTH  external weight bus
- ext_weight_en_o  out  1  weight load strobe
- ext_input_o  out  ROW*WIDTH  external input bus
- ext_valid_o  out  1  external input valid
- ext_result_i  in  COL*WIDTH  array result
- ext_result_valid_i  in  1  array result valid
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async, rstn_i low):
  - FSM=IDLE; all counters and FIFO pointers cleared.
  - All outputs 0, including r_valid_o, w_ready_o, x_ready_o, ext_en_o, ext_* buses/strobes, busy_o and done_o.
  - Reset mid-job aborts the job and drops FIFO contents.
- All ext_* outputs and done_o are registered (driven from flops).
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, FINISH.
- IDLE:
  - ext_en_o=0.
  - start_i=1 latches n_vec_i, clears w_cnt/x_cnt/d_cnt, sets ext_en_o=1 and goes to LOAD_W.
  - start_i is ignored in every other state.
- LOAD_W:
  - w_ready_o=1.
  - Each accepted beat (w_valid_i & w_ready_o) registers ext_weight_o=w_data_i and ext_weight_en_o=1 for the next cycle; otherwise ext_weight_en_o=0.
  - After ROW beats: go to STREAM, or to FINISH if n_vec=0.
  - Gaps in w_valid_i are legal.
- STREAM:
  - x_ready_o = FIFO free slots (counting entries in flight) >= ROW+1.
  - Each accepted beat registers ext_input_o=x_data_i and ext_valid_o=1.
  - A cycle with no accept drives ext_valid_o=0 and ext_input_o=0.
  - After n_vec beats: go to DRAIN.
- DRAIN:
  - ext_valid_o=1, ext_input_o=0 for exactly ROW-1 cycles, independent of FIFO state; the STREAM reservation guarantees space.
  - Then go to FINISH.
- FINISH:
  - ext_valid_o=0, ext_en_o=0, done_o=1 for one cycle, then IDLE.
  - The FIFO keeps its contents; the host may drain after done_o.
- Result capture:
  - In any non-IDLE state, ext_result_valid_i=1 pushes ext_result_i into the FIFO in the same cycle.
  - A push when full is a protocol violation: the entry is dropped and sticky overflow flag ovf_r is set; ovf_r clears only on reset.
- Result FIFO:
  - First-word fall-through: r_valid_o = !empty; r_data_o = head entry.
  - Pop on r_valid_o & r_ready_i.
  - Simultaneous push and pop when full is allowed: count unchanged, no overflow.
  - Simultaneous push and pop when empty: the pushed entry appears next cycle.
  - Pointers wrap modulo RES_DEPTH.
- Counters:
  - w_cnt: $clog2(ROW+1) bits; x_cnt: n_vec width; d_cnt: $clog2(ROW) bits.
  - All saturate-free; each is reset on entry to its state.
- ext_weight_o and ext_input_o hold their last value when their strobe is low, except ext_input_o, which is forced to 0 in DRAIN and on idle STREAM cycles.

Test Plan:
- Reset mid-STREAM (after 2 of 5 vectors) -> all outputs 0 while rstn_i low; FIFO empty; FSM IDLE after release; next start_i runs the full job.
- ROW=4 job, start_i with n_vec=0, 4 weight beats 0x01..0x04 back-to-back -> ext_weight_en_o high 4 consecutive cycles with matching ext_weight_o; done_o pulses once; ext_valid_o never high.
- n_vec=3, continuous x_valid_i, model array asserting ext_result_valid_i 3 cycles after each ext_valid_o -> exactly 3 cycles with nonzero ext_input_o, then 3 DRAIN cycles with ext_valid_o=1 and zero input; 3 results popped in order; done_o after DRAIN.
- Host holds r_ready_i=0, RES_DEPTH=8, ROW=4, 6 results pending -> x_ready_o drops once free slots < 5; ext_valid_o gaps observed; no overflow; all results later popped in order.
- Full FIFO with simultaneous push and pop -> occupancy stays 8; ovf_r stays 0; data order preserved through pointer wrap.
- Forced push while full -> ovf_r=1; entry dropped; existing 8 entries intact.
